puf_tune_ctrl: RTL

- Initiator/driver side of the arbiter PUF: generates challenges, samples the PUF response and counts ones.
- Closed-loop binary-search calibration of tune_level until response bias is within tolerance of 50%.
- Drives the PUF's challenge_d and tune_level inputs and consumes its response. Sits between the BIST sequencer and the PUF core.

---
 rtl/puf_tune_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/puf_tune_ctrl.sv
// puf_tune_ctrl: challenge generator and closed-loop tuner for an arbiter PUF.
// For each evaluation it applies N_EVAL pseudo-random challenges from a Galois
// LFSR and counts the ones in the synchronized response. It then binary-searches
// tune_level until the ones count is within TOL of N_EVAL/2.
//
// Ports:
//   clk         system clock, also the PUF launch clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle calibration request (ignored unless idle)
//   response    raw arbiter output, asynchronous to clk
//   challenge_d current challenge to the PUF
//   tune_level  current tune code to the PUF
//   busy        high from accepted start until done
//   done        one-cycle pulse at end of calibration
//   locked      calibration succeeded (held until next start)
//   fail        calibration exhausted its steps (held until next start)
//   ones_count  ones count of the last completed evaluation
module puf_tune_ctrl #(
  parameter int              N_CB     = 64,
  parameter int              K        = 5,
  parameter int              LOG_EVAL = 8,
  parameter int              SETTLE   = 4,
  parameter int              TOL      = 16,
  parameter logic [N_CB-1:0] SEED     = 64'h0123456789ABCDEF,
  parameter logic [N_CB-1:0] TAPS     = 64'hD800000000000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                response,
  output logic [N_CB-1:0]     challenge_d,
  output logic [K-1:0]        tune_level,
  output logic                busy,
  output logic                done,
  output logic                locked,
  output logic                fail,
  output logic [LOG_EVAL:0]   ones_count
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [LOG_EVAL:0] HALF        = (LOG_EVAL+1)'(1 << (LOG_EVAL - 1));
  localparam logic [K-1:0]      TUNE_MID    = K'(1 << (K - 1));
  localparam logic [K-1:0]      STEP_INIT   = K'(1 << (K - 2));

  typedef enum logic [2:0] {IDLE, HOLD, SAMPLE, EVAL, ADJUST, FIN} state_t;

  state_t              state;
  logic                resp_p0;
  logic                resp_s;
  logic [K-1:0]        step;
  logic [LOG_EVAL:0]   acc;
  logic [LOG_EVAL-1:0] idx;
  logic [SW-1:0]       settle;

  function automatic logic [N_CB-1:0] lfsr_next(input logic [N_CB-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Move the tune code by +/-stp, clamping to the code range.
  function automatic logic [K-1:0] sat_tune(input logic [K-1:0] lvl,
                                            input logic [K-1:0] stp,
                                            input logic         up);
    logic signed [K+1:0] s;
    s = $signed({2'b00, lvl});
    if (up) s = s + $signed({2'b00, stp});
    else    s = s - $signed({2'b00, stp});
    if (s < 0)                            return '0;
    if (s > $signed({2'b00, {K{1'b1}}}))  return '1;
    return s[K-1:0];
  endfunction

  // True when |a - N_EVAL/2| <= TOL.
  function automatic logic bias_ok(input logic [LOG_EVAL:0] a);
    logic signed [LOG_EVAL+2:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, HALF});
    if (d < 0) d = -d;
    return d <= $signed((LOG_EVAL+3)'(TOL));
  endfunction

  // Response synchronizer: resp_p0 -> resp_s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_p0 <= 1'b0;
      resp_s  <= 1'b0;
    end else begin
      resp_p0 <= response;
      resp_s  <= resp_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      challenge_d <= SEED;
      tune_level  <= TUNE_MID;
      step        <= '0;
      acc         <= '0;
      idx         <= '0;
      settle      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      ones_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            locked      <= 1'b0;
            fail        <= 1'b0;
            ones_count  <= '0;
            challenge_d <= SEED;
            tune_level  <= TUNE_MID;
            step        <= STEP_INIT;
            acc         <= '0;
            idx         <= '0;
            settle      <= '0;
            busy        <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (settle == SETTLE_LAST) begin
            settle <= '0;
            state  <= SAMPLE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        SAMPLE: begin
          acc         <= acc + (LOG_EVAL+1)'(resp_s);
          challenge_d <= lfsr_next(challenge_d);
          idx         <= idx + 1'b1;
          state       <= (idx == '1) ? EVAL : HOLD;
        end
        EVAL: begin
          ones_count <= acc;
          if (bias_ok(acc)) begin
            locked <= 1'b1;
            state  <= FIN;
          end else if (step == '0) begin
            fail  <= 1'b1;
            state <= FIN;
          end else begin
            state <= ADJUST;
          end
        end
        ADJUST: begin
          // Too many ones raises the code, too few lowers it.
          if (acc > HALF)      tune_level <= sat_tune(tune_level, step, 1'b1);
          else if (acc < HALF) tune_level <= sat_tune(tune_level, step, 1'b0);
          step  <= step >> 1;
          acc   <= '0;
          idx   <= '0;
          state <= HOLD;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
